// File: rtl/des_key_pkg.sv
// -----------------------------------------------------------------------------
// des_key_pkg
// Shared definitions for the DES round-key scheduler:
//   - half/CD/subkey vector types. These use FIPS bit numbering, so vector
//     index k is FIPS bit k.
//   - PC-2 selection table, per-round shift schedule, FSM state encoding.
//   - FIPS-numbered circular rotate helpers for the 28-bit halves.
// -----------------------------------------------------------------------------
package des_key_pkg;

  localparam int HALF_W = 28;
  localparam int KEY_W  = 48;
  localparam int CD_W   = 56;

  typedef logic [HALF_W:1] half_t;
  typedef logic [CD_W:1]   cd_t;
  typedef logic [KEY_W:1]  subkey_t;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SHIFT  = 2'd1,
    ST_HOLD   = 2'd2,
    ST_FINISH = 2'd3
  } state_t;

  // PC2_TABLE[j] is the CD bit that feeds subkey bit j.
  localparam logic [5:0] PC2_TABLE [1:48] = '{
    6'd14, 6'd17, 6'd11, 6'd24, 6'd1,  6'd5,
    6'd3,  6'd28, 6'd15, 6'd6,  6'd21, 6'd10,
    6'd23, 6'd19, 6'd12, 6'd4,  6'd26, 6'd8,
    6'd16, 6'd7,  6'd27, 6'd20, 6'd13, 6'd2,
    6'd41, 6'd52, 6'd31, 6'd37, 6'd47, 6'd55,
    6'd30, 6'd40, 6'd51, 6'd45, 6'd33, 6'd48,
    6'd44, 6'd49, 6'd39, 6'd56, 6'd34, 6'd53,
    6'd46, 6'd42, 6'd50, 6'd36, 6'd29, 6'd32
  };

  // Entry i holds the shift amount of round i+1.
  localparam logic [1:0] SHIFT_SCHED [0:15] = '{
    2'd1, 2'd1, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2,
    2'd1, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd1
  };

  // FIPS left rotate: bit k takes bit k+amt (wrapping 28 -> 1).
  function automatic half_t rotl_fips(input half_t h, input logic [1:0] amt);
    half_t r;
    case (amt)
      2'd1:    r = {h[1], h[28:2]};
      2'd2:    r = {h[2:1], h[28:3]};
      default: r = h;
    endcase
    return r;
  endfunction

  // FIPS right rotate: inverse of rotl_fips.
  function automatic half_t rotr_fips(input half_t h, input logic [1:0] amt);
    half_t r;
    case (amt)
      2'd1:    r = {h[27:1], h[28]};
      2'd2:    r = {h[26:1], h[28:27]};
      default: r = h;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/des_round_key_scheduler_pc2.sv
// -----------------------------------------------------------------------------
// des_pc2_permute
// Purely combinational PC-2 compression (56 -> 48 bits), FIPS bit numbering.
// Ports:
//   i_cd     [56:1]  rotated C/D pair, CD[28:1] = C, CD[56:29] = D
//   o_subkey [48:1]  PC-2 output, index j = FIPS PC-2 output bit j
// -----------------------------------------------------------------------------
module des_pc2_permute
  import des_key_pkg::*;
(
  input  logic [CD_W:1]  i_cd,
  output logic [KEY_W:1] o_subkey
);

  for (genvar j = 1; j <= KEY_W; j++) begin : g_pc2
    assign o_subkey[j] = i_cd[PC2_TABLE[j]];
  end

endmodule

// File: rtl/des_round_key_scheduler.sv
// -----------------------------------------------------------------------------
// des_round_key_scheduler
// Latches the C0/D0 halves from PC-1, rotates them round by round, and applies
// PC-2. The sixteen round subkeys are presented over a valid/ready handshake.
// The order is K1..K16 for encrypt and K16..K1 for decrypt.
//
// Optional feature macro: KEY_SCHED_DECRYPT_EN
//   defined   : DECRYPT (sampled with LOAD) selects the reverse order
//   undefined : DECRYPT is ignored, only the encrypt order exists
//
// Ports:
//   CLK            rising-edge clock
//   RESET_BAR      asynchronous active-low reset
//   LOAD           start strobe, honoured only when idle
//   DECRYPT        1 = reverse subkey order (sampled with LOAD)
//   LEFT_HALF_IN   [27:0] PC-1 bits 56:29 (D), bit 0 = FIPS bit 29
//   RIGHT_HALF_IN  [27:0] PC-1 bits 28:1  (C), bit 0 = FIPS bit 1
//   SUBKEY_READY   consumer accepts the presented subkey
//   SUBKEY         [48:1] round subkey, index j = FIPS PC-2 output bit j
//   SUBKEY_VALID   SUBKEY holds a valid key
//   ROUND_NUM      presentation round 1..16
//   BUSY           high whenever not idle
//   DONE           one-cycle pulse after the 16th handshake
// -----------------------------------------------------------------------------
module des_round_key_scheduler
  import des_key_pkg::*;
#(
  parameter int ROUNDS  = 16,
  parameter int ROUND_W = 5
) (
  input  logic               CLK,
  input  logic               RESET_BAR,
  input  logic               LOAD,
  input  logic               DECRYPT,
  input  logic [HALF_W-1:0]  LEFT_HALF_IN,
  input  logic [HALF_W-1:0]  RIGHT_HALF_IN,
  input  logic               SUBKEY_READY,
  output logic [KEY_W:1]     SUBKEY,
  output logic               SUBKEY_VALID,
  output logic [ROUND_W-1:0] ROUND_NUM,
  output logic               BUSY,
  output logic               DONE
);

  state_t             r_state;
  state_t             w_state_nxt;
  half_t              r_c;
  half_t              r_d;
  half_t              w_c_rot;
  half_t              w_d_rot;
  half_t              w_c_nxt;
  half_t              w_d_nxt;
  logic [ROUND_W-1:0] r_round;
  logic [ROUND_W-1:0] w_round_nxt;
  subkey_t            r_subkey;
  subkey_t            w_subkey_nxt;
  subkey_t            w_pc2;
  logic               r_valid;
  logic               w_valid_nxt;
  logic               r_busy;
  logic               w_busy_nxt;
  logic               r_done;
  logic               w_done_nxt;
  logic               w_last_round;
  logic [3:0]         w_enc_idx;
  logic [1:0]         w_enc_amt;

  assign w_last_round = (r_round == ROUND_W'(ROUNDS));
  // Round r uses schedule entry r-1.
  assign w_enc_idx    = 4'(r_round - ROUND_W'(1));
  assign w_enc_amt    = SHIFT_SCHED[w_enc_idx];

`ifdef KEY_SCHED_DECRYPT_EN
  logic       r_decrypt;
  logic [3:0] w_dec_idx;
  logic [1:0] w_dec_amt;

  // Decrypt round r >= 2 undoes encrypt round 18-r, i.e. schedule entry 17-r.
  // Round 1 does not rotate: after 16 rounds C/D are back at C0/D0, so K16
  // comes straight from the loaded halves.
  assign w_dec_idx = 4'(ROUND_W'(ROUNDS + 1) - r_round);
  assign w_dec_amt = (r_round == ROUND_W'(1)) ? 2'd0 : SHIFT_SCHED[w_dec_idx];

  // Mode register, captured together with the halves.
  always_ff @(posedge CLK or negedge RESET_BAR) begin
    if (!RESET_BAR) begin
      r_decrypt <= 1'b0;
    end else if ((r_state == ST_IDLE) && LOAD) begin
      r_decrypt <= DECRYPT;
    end else begin
      r_decrypt <= r_decrypt;
    end
  end

  // Rotated halves for the current round, direction chosen by the mode.
  always_comb begin
    if (r_decrypt) begin
      w_c_rot = rotr_fips(r_c, w_dec_amt);
      w_d_rot = rotr_fips(r_d, w_dec_amt);
    end else begin
      w_c_rot = rotl_fips(r_c, w_enc_amt);
      w_d_rot = rotl_fips(r_d, w_enc_amt);
    end
  end
`else
  logic w_unused_decrypt;
  assign w_unused_decrypt = DECRYPT;

  // Rotated halves for the current round (encrypt order only).
  always_comb begin
    w_c_rot = rotl_fips(r_c, w_enc_amt);
    w_d_rot = rotl_fips(r_d, w_enc_amt);
  end
`endif

  des_pc2_permute u_pc2 (
    .i_cd     ({w_d_rot, w_c_rot}),
    .o_subkey (w_pc2)
  );

  // FSM state register.
  always_ff @(posedge CLK or negedge RESET_BAR) begin
    if (!RESET_BAR) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // FSM next-state logic.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: begin
        if (LOAD) begin
          w_state_nxt = ST_SHIFT;
        end else begin
          w_state_nxt = ST_IDLE;
        end
      end
      ST_SHIFT: begin
        w_state_nxt = ST_HOLD;
      end
      ST_HOLD: begin
        if (SUBKEY_READY) begin
          if (w_last_round) begin
            w_state_nxt = ST_FINISH;
          end else begin
            w_state_nxt = ST_SHIFT;
          end
        end else begin
          w_state_nxt = ST_HOLD;
        end
      end
      ST_FINISH: begin
        w_state_nxt = ST_IDLE;
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  // FSM output/datapath logic: next values of the registered outputs and C/D.
  always_comb begin
    w_c_nxt      = r_c;
    w_d_nxt      = r_d;
    w_round_nxt  = r_round;
    w_subkey_nxt = r_subkey;
    w_valid_nxt  = r_valid;
    case (r_state)
      ST_IDLE: begin
        if (LOAD) begin
          w_c_nxt     = RIGHT_HALF_IN;
          w_d_nxt     = LEFT_HALF_IN;
          w_round_nxt = ROUND_W'(1);
        end else begin
          w_round_nxt = r_round;
        end
      end
      ST_SHIFT: begin
        w_c_nxt      = w_c_rot;
        w_d_nxt      = w_d_rot;
        w_subkey_nxt = w_pc2;
        w_valid_nxt  = 1'b1;
      end
      ST_HOLD: begin
        if (SUBKEY_READY) begin
          w_valid_nxt = 1'b0;
          if (w_last_round) begin
            w_round_nxt = r_round;
          end else begin
            w_round_nxt = r_round + ROUND_W'(1);
          end
        end else begin
          w_valid_nxt = r_valid;
        end
      end
      ST_FINISH: begin
        w_valid_nxt = 1'b0;
      end
      default: begin
        w_valid_nxt = 1'b0;
      end
    endcase
    w_busy_nxt = (w_state_nxt != ST_IDLE);
    w_done_nxt = (w_state_nxt == ST_FINISH);
  end

  // Datapath and output registers.
  always_ff @(posedge CLK or negedge RESET_BAR) begin
    if (!RESET_BAR) begin
      r_c      <= '0;
      r_d      <= '0;
      r_round  <= '0;
      r_subkey <= '0;
      r_valid  <= 1'b0;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
    end else begin
      r_c      <= w_c_nxt;
      r_d      <= w_d_nxt;
      r_round  <= w_round_nxt;
      r_subkey <= w_subkey_nxt;
      r_valid  <= w_valid_nxt;
      r_busy   <= w_busy_nxt;
      r_done   <= w_done_nxt;
    end
  end

  assign SUBKEY       = r_subkey;
  assign SUBKEY_VALID = r_valid;
  assign ROUND_NUM    = r_round;
  assign BUSY         = r_busy;
  assign DONE         = r_done;

endmodule
